// File: rtl/scm_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : scm_burst_reader
// Brief   : Burst read master for a 1R1W latch-based SCM; streams words out
//           through a 2-entry skid FIFO on a valid/ready port with last flag.
// Revision: 1.0 - initial release
// ============================================================================
module scm_burst_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_len_i,
    input  logic                  flush_i,
    output logic                  ReadEnable_o,
    output logic [ADDR_WIDTH-1:0] ReadAddr_o,
    input  logic [DATA_WIDTH-1:0] ReadData_i,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_last_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [1:0]              fifo_last_q;
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    drain_done;
    logic [2:0]              occupancy;
    logic [2:0]              issue_limit;

    assign data_valid_o = (count_q != 2'd0);
    assign data_o       = fifo_data_q[rd_ptr_q];
    assign data_last_o  = data_valid_o & fifo_last_q[rd_ptr_q];
    assign pop          = data_valid_o & data_ready_i;
    assign push         = inflight_q & ~flush_i;

    // Words buffered plus the one in flight, less the one leaving now, must
    // stay below the FIFO depth so the returning word always has a slot.
    assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue_limit  = 3'd2 + {2'b00, pop};
    assign issue        = (state_q == S_READ) && (occupancy < issue_limit);

    assign ReadEnable_o = issue;
    assign ReadAddr_o   = addr_q;
    assign cmd_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign drain_done   = (count_q == {1'b0, pop}) && !inflight_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        if (flush_i) begin
            state_d  = S_IDLE;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_d  = cmd_addr_i;
                        rem_d   = cmd_len_i;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr_d          = addr_q + ADDR_WIDTH'(1);
                        rem_d           = rem_q - ADDR_WIDTH'(1);
                        inflight_d      = 1'b1;
                        inflight_last_d = (rem_q == '0);
                        if (rem_q == '0) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= 2'b00;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ReadData_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scm_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_scm_burst_reader
// Brief   : Directed bench with an SCM model and an expected-beat queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scm_burst_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          flush = 1'b0;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic          dvalid;
    logic          dready = 1'b1;
    logic [DW-1:0] dout;
    logic          dlast;
    logic          busy;

    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;
    int     outstanding = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    beat_t expq[$];

    scm_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .flush_i     (flush),
        .ReadEnable_o(ren),
        .ReadAddr_o  (raddr),
        .ReadData_i  (rdata),
        .data_valid_o(dvalid),
        .data_ready_i(dready),
        .data_o      (dout),
        .data_last_o (dlast),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input int a);
        return 32'hA000_0000 + DW'(a % NW);
    endfunction

    // SCM read port: data for the registered address appears one cycle later
    always @(posedge clk) if (ren) rdata <= word(int'(raddr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted command queues its expected beats; each valid
    // beat must match the queue head, and only a taken beat retires it.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            outstanding = 0;
            chk("rst_valid", dvalid, 0);
            chk("rst_ren", ren, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
        end else begin
            if (dvalid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", dout, 0);
                    n_fail += (dout == 0) ? 1 : 0;
                end else begin
                    chk("beat_data", dout, expq[0].d);
                    chk("beat_last", dlast, expq[0].l);
                    if (dready) void'(expq.pop_front());
                end
            end
            if (ren && !busy) chk("ren_outside_busy", ren, 0);
            outstanding += (ren ? 1 : 0) - ((dvalid && dready) ? 1 : 0);
            if (outstanding > 2) chk("fifo_overflow", outstanding, 2);
            if (flush) begin
                expq.delete();
                outstanding = 0;
            end else if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    beat_t b;
                    b.d = word(int'(cmd_addr) + i);
                    b.l = (i == int'(cmd_len));
                    expq.push_back(b);
                end
            end
        end
    end

    task automatic run_burst(input int addr, input int len,
                             output logic [DW-1:0] first_d, output logic [DW-1:0] last_d);
        int     first_off = -1;
        int     last_off = -1;
        int     idle_off = -1;
        int     beats = 0;
        int     issues = 0;
        longint c0;
        first_d = '0;
        last_d  = '0;
        dready    = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = AW'(len);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        cmd_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ren) begin
                chk("read_addr", raddr, (addr + issues) % NW);
                issues++;
            end
            if (dvalid) begin
                if (first_off < 0) begin
                    first_off = int'(cyc - c0);
                    first_d   = dout;
                end
                if (dlast) begin
                    last_off = int'(cyc - c0);
                    last_d   = dout;
                end
                beats++;
            end
            if (!busy) begin
                idle_off = int'(cyc - c0);
                break;
            end
            @(posedge clk); #1;
        end
        chk("first_valid_latency", first_off, 2);
        chk("last_beat_latency", last_off, len + 2);
        chk("idle_latency", idle_off, len + 3);
        chk("beat_count", beats, len + 1);
        chk("issue_count", issues, len + 1);
    endtask

    initial begin
        logic [DW-1:0] fd, ld, held;
        int            beats;
        logic          stalled;
        logic [3:0]    pat;

        #2;
        chk("init_valid", dvalid, 0);
        chk("init_data", dout, 0);
        chk("init_last", dlast, 0);
        chk("init_raddr", raddr, 0);
        chk("init_cmd_ready", cmd_ready, 1);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(7, 0, fd, ld);
        chk("single_data", fd, 32'hA000_0007);
        chk("single_last_data", ld, 32'hA000_0007);

        run_burst(2, 3, fd, ld);
        chk("burst4_first", fd, 32'hA000_0002);
        chk("burst4_last", ld, 32'hA000_0005);

        run_burst(30, 3, fd, ld);
        chk("wrap_first", fd, 32'hA000_001E);
        chk("wrap_last", ld, 32'hA000_0001);

        run_burst(0, 31, fd, ld);
        chk("full_first", fd, 32'hA000_0000);
        chk("full_last", ld, 32'hA000_001F);

        // Backpressure with ready pattern 1,0,0,1
        pat       = 4'b1001;
        cmd_addr  = AW'(4);
        cmd_len   = AW'(7);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        beats   = 0;
        stalled = 1'b0;
        held    = '0;
        for (int k = 0; k < 200 && busy; k++) begin
            dready = pat[3 - (k % 4)];
            if (stalled) chk("stall_hold", dout, held);
            if (dvalid && dready) begin
                chk("bp_word", dout, 32'hA000_0004 + DW'(beats));
                beats++;
            end
            stalled = dvalid && !dready;
            held    = dout;
            @(posedge clk); #1;
        end
        chk("bp_beats", beats, 8);
        chk("bp_idle", busy, 0);
        dready = 1'b1;

        // Flush on the third beat of a 6-word burst
        cmd_addr  = AW'(0);
        cmd_len   = AW'(5);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        beats = 0;
        for (int k = 0; k < 50; k++) begin
            if (dvalid) beats++;
            if (beats == 3) break;
            @(posedge clk); #1;
        end
        chk("flush_third_beat", dout, 32'hA000_0002);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", dvalid, 0);
        chk("flush_cmd_ready", cmd_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        run_burst(10, 0, fd, ld);
        chk("post_flush_data", fd, 32'hA000_000A);

        // Flush wins over a command in IDLE
        cmd_addr  = AW'(3);
        cmd_len   = AW'(2);
        cmd_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_cmd_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset mid-burst
        cmd_addr  = AW'(0);
        cmd_len   = AW'(15);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", dvalid, 0);
        chk("arst_data", dout, 0);
        chk("arst_last", dlast, 0);
        chk("arst_ren", ren, 0);
        chk("arst_raddr", raddr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(2, 3, fd, ld);
        chk("post_rst_first", fd, 32'hA000_0002);
        chk("post_rst_last", ld, 32'hA000_0005);

        repeat (3) @(posedge clk);
        #1;
        chk("model_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
